pipe_fetch: RTL
===============

Name: pipe_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline. It owns the PC register and the IF/ID pipeline register.
- It issues instruction-memory requests and consumes ID's redirect outputs: bpc, jpc, pcsource, jr target da.
- It consumes ID's stall request wpcir and delivers dpc4/inst to ID.
- Architectural branch delay slot (one slot): a redirect applies to the fetch after the slot.
- The instruction memory may insert wait states, so the fetch side is handshaked and buffered.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0000, bubble word (sll $0,$0,0) placed in IF/ID when no instruction is delivered.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pcsource  in  2  ID next-PC select: 00 pc+4, 01 bpc, 10 da (jr), 11 jpc. Qualified by ivalid.
- bpc  in  32  branch target from ID.
- jpc  in  32  jump target from ID.
- da  in  32  forwarded rs value from ID (jr target).
- wpcir  in  1  stall request from ID, active high: hold PC and IF/ID.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  fetch completes this cycle.
- pc  out  32  current fetch PC.
- dpc4  out  32  IF/ID: PC+4 of the held instruction.
- inst  out  32  IF/ID: instruction.
- ivalid  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (async, any state, mid-fetch included):
  - pc=RESET_PC, dpc4=0, inst=NOP_INST, ivalid=0.
  - State RUN, redir_pend=0, hold buffer cleared.
  - imem_req=0 while resetn=0; imem_req=1 from the first clock after reset release.
- imem_req=1 whenever out of reset and state==RUN; imem_addr=pc. In state HOLD, imem_req=0.
- fetch_done = RUN & imem_ready, or state==HOLD. fetched_word = imem_rdata in RUN, hold_buf in HOLD.
- Live redirect: live_redir = ivalid & ~wpcir & (pcsource!=00). live_tgt = bpc / da / jpc per pcsource.
- Effective redirect: eff_redir = live_redir | redir_pend; eff_tgt = live_tgt if live_redir, else redir_tgt.
- State RUN:
  - wpcir=0, fetch_done: IF/ID <= {pc+4, fetched_word, 1}.
    - pc <= eff_tgt if eff_redir, else pc+4.
    - redir_pend <= 0.
  - wpcir=0, no imem_ready: IF/ID <= {dpc4, NOP_INST, 0} (bubble); pc holds.
    - If live_redir: redir_pend <= 1, redir_tgt <= live_tgt. The slot fetch is still outstanding.
  - wpcir=1, imem_ready: hold_buf <= imem_rdata; go to HOLD. pc and IF/ID hold.
  - wpcir=1, no imem_ready: everything holds; the request stays asserted.
- State HOLD:
  - wpcir=1: hold everything.
  - wpcir=0: load IF/ID from hold_buf; update pc exactly as in RUN; go to RUN.
- Redirects are ignored while wpcir=1: the branch in ID is re-presented when the stall clears.
- pc+4 wraps modulo 2^32 with no error. Targets are used unaligned as given (ID guarantees alignment).
- Latency: the instruction at pc is visible on inst the cycle after imem_ready with wpcir=0.
- Zero wait-state memory, no stalls: one instruction per cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - PC_SEQ=2'b00, PC_BR=2'b01, PC_JR=2'b10, PC_J=2'b11.
  - NOP_INST.
  - Fetch state enum {RUN, HOLD}.
- Sub-module pipe_pc_sel: combinational next-PC mux (pc4, bpc, da, jpc, pcsource) -> live_tgt. Shared with the ID stage's existing mux4x32 style.

Test Plan:
- Reset, imem_ready tied 1, sequential code: pc goes 0,4,8,C on successive cycles; inst at cycle 2 = word@4; ivalid=1 from the cycle after the first fetch.
- Branch at 0x10 with pcsource=01, bpc=0x40: the delay slot at 0x14 still enters IF/ID; the next fetch address is 0x40; no bubble.
- Delay-slot fetch with 3 wait states while the branch leaves ID (pcsource=11, jpc=0x100): 3 bubbles (ivalid=0, inst=0); after the slot is delivered, pc=0x100.
- wpcir=1 for 2 cycles while imem_ready pulses once: state HOLD, imem_req=0, IF/ID unchanged; on release the buffered word is delivered and pc advances by 4 once, with no lost or duplicated instruction.
- jr with pcsource=10, da=0x2000, asserted with wpcir=1 then 0: no redirect during the stall; pc=0x2000 after the slot fetch completes.
- resetn dropped mid-wait (imem_ready=0) and mid-HOLD: immediate pc=RESET_PC, ivalid=0, imem_req=0; the fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stages: next-PC select codes,
// the bubble instruction word and the fetch-side state type.
package pipe_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pipe_pc_sel.sv
// Next-PC target mux driven by ID's pcsource; same shape as ID's mux4x32.
module pipe_pc_sel
  import pipe_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  input  logic [1:0]  pcsource,
  output logic [31:0] live_tgt
);

  always_comb begin
    live_tgt = pc4;
    case (pcsource)
      PC_SEQ:  live_tgt = pc4;
      PC_BR:   live_tgt = bpc;
      PC_JR:   live_tgt = da;
      PC_J:    live_tgt = jpc;
      default: live_tgt = pc4;
    endcase
  end

endmodule

// File: rtl/pipe_fetch.sv
// IF stage: owns the PC and the IF/ID register, fetches through a handshaked
// instruction port and honours a one-slot branch delay.
module pipe_fetch
  import pipe_pkg::fetch_state_e, pipe_pkg::RUN, pipe_pkg::HOLD, pipe_pkg::PC_SEQ;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] da,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        ivalid
);

  fetch_state_e state, state_n;
  logic [31:0]  pc_n, dpc4_n, inst_n, hold_buf, hold_buf_n, redir_tgt, redir_tgt_n;
  logic         ivalid_n, redir_pend, redir_pend_n;
  logic [31:0]  pc4, live_tgt, eff_tgt, fetched_word;
  logic         fetch_done, live_redir, eff_redir;

  assign pc4 = pc + 32'd4;

  pipe_pc_sel u_pc_sel (
    .pc4      (pc4),
    .bpc      (bpc),
    .da       (da),
    .jpc      (jpc),
    .pcsource (pcsource),
    .live_tgt (live_tgt)
  );

  assign imem_req     = resetn && (state == RUN);
  assign imem_addr    = pc;
  assign fetch_done   = (state == HOLD) || imem_ready;
  assign fetched_word = (state == HOLD) ? hold_buf : imem_rdata;
  // A branch only counts while it is really in ID and ID is not stalling it.
  assign live_redir   = ivalid && !wpcir && (pcsource != PC_SEQ);
  assign eff_redir    = live_redir || redir_pend;
  assign eff_tgt      = live_redir ? live_tgt : redir_tgt;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_n      = state;
    pc_n         = pc;
    dpc4_n       = dpc4;
    inst_n       = inst;
    ivalid_n     = ivalid;
    hold_buf_n   = hold_buf;
    redir_pend_n = redir_pend;
    redir_tgt_n  = redir_tgt;

    if (!wpcir && fetch_done) begin
      // The word completing now is the delay slot when a redirect is active.
      state_n      = RUN;
      dpc4_n       = pc4;
      inst_n       = fetched_word;
      ivalid_n     = 1'b1;
      pc_n         = eff_redir ? eff_tgt : pc4;
      redir_pend_n = 1'b0;
    end else if (!wpcir) begin
      inst_n   = NOP_INST;
      ivalid_n = 1'b0;
      if (live_redir) begin
        redir_pend_n = 1'b1;
        redir_tgt_n  = live_tgt;
      end
    end else if (state == RUN && imem_ready) begin
      // Park the completed word so the memory handshake is not lost during a stall.
      hold_buf_n = imem_rdata;
      state_n    = HOLD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= RUN;
      pc         <= RESET_PC;
      dpc4       <= 32'd0;
      inst       <= NOP_INST;
      ivalid     <= 1'b0;
      hold_buf   <= 32'd0;
      redir_pend <= 1'b0;
      redir_tgt  <= 32'd0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      dpc4       <= dpc4_n;
      inst       <= inst_n;
      ivalid     <= ivalid_n;
      hold_buf   <= hold_buf_n;
      redir_pend <= redir_pend_n;
      redir_tgt  <= redir_tgt_n;
    end
  end

endmodule
